// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// owner encoding and the default byte-address width.
package dmem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_t;

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-requester round-robin picker. On simultaneous requests the requester
// not served last wins; the last-served register resets to DMA so the CPU
// wins the first contest.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic   Clock,
    input  logic   Reset,
    input  logic   req_cpu,
    input  logic   req_dma,
    input  logic   take,
    output owner_t pick
);

    owner_t last;

    // Choose the winner from the current requests and the last-served owner
    always_comb begin
        pick = OWN_CPU;
        if (req_cpu && req_dma)
            pick = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
        else if (req_dma)
            pick = OWN_DMA;
    end

    // Remember who was granted whenever a grant is actually taken
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)
            last <= OWN_DMA;
        else if (take)
            last <= pick;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one byte-wide synchronous data memory between a CPU and a
// DMA/debug requester issuing 16-bit big-endian word accesses.
// Optional macro DMEM_ARB_RR_EN: round-robin arbitration; when undefined,
// the CPU has fixed priority on simultaneous requests.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              CpuReq,
    input  logic              CpuWe,
    input  logic [15:0]       CpuAddr,
    input  logic [15:0]       CpuWData,
    output logic              CpuAck,
    output logic [15:0]       CpuRData,
    input  logic              DmaReq,
    input  logic              DmaWe,
    input  logic [15:0]       DmaAddr,
    input  logic [15:0]       DmaWData,
    output logic              DmaAck,
    output logic [15:0]       DmaRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [7:0]        MemWData,
    output logic              MemWe,
    output logic              MemRe,
    input  logic [7:0]        MemRData
);

    state_t              state;
    owner_t              owner;
    owner_t              pick;
    logic                take;
    logic                we_l;
    logic [ADDR_W-1:0]   addr_l;
    logic [7:0]          wlo_l;
    logic [7:0]          hi_byte;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [15:0]         sel_wdata;
    logic                unused_addr_hi;

    // Only the low ADDR_W address bits reach the memory
    assign unused_addr_hi = ^{CpuAddr, DmaAddr};

    assign take = (state == ST_IDLE) && (CpuReq || DmaReq);

`ifdef DMEM_ARB_RR_EN
    dmem_rr_pick u_pick (
        .Clock   (Clock),
        .Reset   (Reset),
        .req_cpu (CpuReq),
        .req_dma (DmaReq),
        .take    (take),
        .pick    (pick)
    );
`else
    assign pick = CpuReq ? OWN_CPU : OWN_DMA;
`endif

    // Route the winning requester's fields toward the latch
    always_comb begin
        sel_we    = CpuWe;
        sel_addr  = CpuAddr[ADDR_W-1:0];
        sel_wdata = CpuWData;
        if (pick == OWN_DMA) begin
            sel_we    = DmaWe;
            sel_addr  = DmaAddr[ADDR_W-1:0];
            sel_wdata = DmaWData;
        end
    end

    // Transaction FSM: strobes are registered on the edge entering HI/LO so
    // they coincide with those states; the low read byte only arrives during
    // DONE, so the word and the ack are registered on the DONE->IDLE edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            owner    <= OWN_CPU;
            we_l     <= 1'b0;
            addr_l   <= '0;
            wlo_l    <= '0;
            hi_byte  <= '0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWe    <= 1'b0;
            MemRe    <= 1'b0;
            CpuAck   <= 1'b0;
            DmaAck   <= 1'b0;
            CpuRData <= '0;
            DmaRData <= '0;
        end else begin
            MemWe  <= 1'b0;
            MemRe  <= 1'b0;
            CpuAck <= 1'b0;
            DmaAck <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        owner    <= pick;
                        we_l     <= sel_we;
                        addr_l   <= sel_addr;
                        wlo_l    <= sel_wdata[7:0];
                        MemAddr  <= sel_addr;
                        MemWData <= sel_wdata[15:8];
                        MemWe    <= sel_we;
                        MemRe    <= !sel_we;
                        state    <= ST_HI;
                    end
                end
                ST_HI: begin
                    MemAddr  <= addr_l + ADDR_W'(1);
                    MemWData <= wlo_l;
                    MemWe    <= we_l;
                    MemRe    <= !we_l;
                    state    <= ST_LO;
                end
                ST_LO: begin
                    hi_byte <= MemRData;
                    state   <= ST_DONE;
                end
                default: begin
                    if (owner == OWN_CPU) begin
                        CpuAck <= 1'b1;
                        if (!we_l)
                            CpuRData <= {hi_byte, MemRData};
                    end else begin
                        DmaAck <= 1'b1;
                        if (!we_l)
                            DmaRData <= {hi_byte, MemRData};
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
